// File: rtl/rtc_time_collector_if.sv
// Bundle between the RTC time collector, the I2C byte-reader stage and the
// display/application logic that consumes the decoded time set.
interface rtc_time_collector_if;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic [5:0] sec_bin;
   logic [5:0] min_bin;
   logic [4:0] hour_bin;
   logic       clock_halt;
   logic       bcd_err;
   logic       time_valid;
   logic [2:0] day_bin;
   logic [4:0] date_bin;
   logic [3:0] month_bin;
   logic [6:0] year_bin;

   modport master (
      output rd_addr,
      input  rd_data,
      output sec_bin, min_bin, hour_bin, clock_halt, bcd_err, time_valid,
      output day_bin, date_bin, month_bin, year_bin
   );

   modport slave (
      input  rd_addr,
      output rd_data,
      input  sec_bin, min_bin, hour_bin, clock_halt, bcd_err, time_valid,
      input  day_bin, date_bin, month_bin, year_bin
   );
endinterface

// File: rtl/rtc_time_collector.sv
// Sequences DS1307 register reads through the byte-reader stage, decodes the BCD
// bytes and publishes a coherent time set. Define RTC_DATE_EN to add calendar fields.
module rtc_time_collector #(
   parameter int FRAME_CYCLES = 64000,
   parameter int HOLD_FRAMES  = 3
) (
   input  logic                 clk_50mhz,
   input  logic                 rst_n,
   rtc_time_collector_if.master bus
);

`ifdef RTC_DATE_EN
   localparam int LAST = 6;
`else
   localparam int LAST = 2;
`endif
   localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

   typedef enum logic [1:0] {HOLD, CAPTURE, PUBLISH} state_t;

   state_t        state, state_nx;
   logic [FW-1:0] frame_cnt;
   logic [3:0]    hold_cnt;
   logic [2:0]    index, index_nx;
   logic [7:0]    shadow [0:LAST];
   logic          frame_tick;

   function automatic logic [7:0] rev_addr(input logic [2:0] idx);
      return {idx[0], idx[1], idx[2], 5'b0};
   endfunction

   function automatic logic [7:0] bcd(input logic [3:0] tens, input logic [3:0] units);
      return {4'b0, tens} * 8'd10 + {4'b0, units};
   endfunction

   assign frame_tick = (frame_cnt == FW'(FRAME_CYCLES - 1));

   always_comb begin
      state_nx = state;
      index_nx = index;
      case (state)
         HOLD:    if (frame_tick && hold_cnt == 4'(HOLD_FRAMES - 1)) state_nx = CAPTURE;
         CAPTURE: begin
            if (index == 3'(LAST)) state_nx = PUBLISH;
            else begin
               state_nx = HOLD;
               index_nx = index + 3'd1;
            end
         end
         PUBLISH: begin
            state_nx = HOLD;
            index_nx = 3'd0;
         end
         default: state_nx = HOLD;
      endcase
   end

   // The frame timer only runs while holding, so every register costs exactly
   // HOLD_FRAMES frames plus its capture cycle.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HOLD;
         frame_cnt   <= '0;
         hold_cnt    <= '0;
         index       <= '0;
         bus.rd_addr <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state       <= state_nx;
         index       <= index_nx;
         bus.rd_addr <= rev_addr(index_nx);
         if (state == HOLD) begin
            frame_cnt <= frame_tick ? '0 : frame_cnt + FW'(1);
            if (frame_tick) hold_cnt <= hold_cnt + 4'd1;
         end
         if (state == CAPTURE) hold_cnt <= '0;
      end
   end

   // NOTE: the shadow bank is a few flops and is reset like other state; each
   // entry is rewritten before any publish uses it.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= LAST; i++) shadow[i] <= 8'h00;
      end else if (state == CAPTURE) begin
         shadow[index] <= bus.rd_data;
      end
   end

   logic [7:0] sec_raw, min_raw, hr_raw, v12;
   logic       sec_bad, min_bad, hr_bad, cal_bad;
   logic [5:0] sec_dec, min_dec;
   logic [4:0] hour_dec;
   logic [2:0] day_dec;
   logic [4:0] date_dec;
   logic [3:0] month_dec;
   logic [6:0] year_dec;
   logic       unused_bits;

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      hr_raw    = 8'd0;
      hr_bad    = 1'b0;
      cal_bad   = 1'b0;
      day_dec   = '0;
      date_dec  = '0;
      month_dec = '0;
      year_dec  = '0;

      sec_raw = bcd({1'b0, shadow[0][6:4]}, shadow[0][3:0]);
      sec_bad = (shadow[0][3:0] > 4'd9) || (sec_raw > 8'd59);
      sec_dec = sec_bad ? 6'd59 : sec_raw[5:0];

      min_raw = bcd({1'b0, shadow[1][6:4]}, shadow[1][3:0]);
      min_bad = (shadow[1][3:0] > 4'd9) || (min_raw > 8'd59);
      min_dec = min_bad ? 6'd59 : min_raw[5:0];

      v12 = bcd({3'b0, shadow[2][4]}, shadow[2][3:0]);
      if (!shadow[2][6]) begin
         hr_raw = bcd({2'b0, shadow[2][5:4]}, shadow[2][3:0]);
         hr_bad = (shadow[2][3:0] > 4'd9) || (hr_raw > 8'd23);
      end else begin
         hr_bad = (shadow[2][3:0] > 4'd9) || (v12 == 8'd0) || (v12 > 8'd12);
         if (v12 == 8'd12) hr_raw = shadow[2][5] ? 8'd12 : 8'd0;
         else              hr_raw = shadow[2][5] ? v12 + 8'd12 : v12;
      end
      hour_dec = hr_bad ? 5'd23 : hr_raw[4:0];

`ifdef RTC_DATE_EN
      begin
         logic [7:0] date_raw, month_raw, year_raw;
         logic       day_bad, date_bad, month_bad, year_bad;
         day_bad   = (shadow[3][2:0] == 3'd0);
         date_raw  = bcd({2'b0, shadow[4][5:4]}, shadow[4][3:0]);
         date_bad  = (shadow[4][3:0] > 4'd9) || (date_raw == 8'd0) || (date_raw > 8'd31);
         month_raw = bcd({3'b0, shadow[5][4]}, shadow[5][3:0]);
         month_bad = (shadow[5][3:0] > 4'd9) || (month_raw == 8'd0) || (month_raw > 8'd12);
         year_raw  = bcd(shadow[6][7:4], shadow[6][3:0]);
         year_bad  = (shadow[6][3:0] > 4'd9) || (year_raw > 8'd99);
         day_dec   = day_bad   ? 3'd7  : shadow[3][2:0];
         date_dec  = date_bad  ? 5'd31 : date_raw[4:0];
         month_dec = month_bad ? 4'd12 : month_raw[3:0];
         year_dec  = year_bad  ? 7'd99 : year_raw[6:0];
         cal_bad   = day_bad | date_bad | month_bad | year_bad;
      end
`endif
   end

`ifdef RTC_DATE_EN
   assign unused_bits = ^{shadow[1][7], shadow[2][7], shadow[3][7:3], shadow[4][7:6], shadow[5][7:5]};
`else
   assign unused_bits = ^{shadow[1][7], shadow[2][7], day_dec, date_dec, month_dec, year_dec, cal_bad};
`endif

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         bus.time_valid <= 1'b0;
         bus.sec_bin    <= '0;
         bus.min_bin    <= '0;
         bus.hour_bin   <= '0;
         bus.clock_halt <= 1'b0;
         bus.bcd_err    <= 1'b0;
      end else begin
         bus.time_valid <= (state == PUBLISH);
         if (state == PUBLISH) begin
            bus.sec_bin    <= sec_dec;
            bus.min_bin    <= min_dec;
            bus.hour_bin   <= hour_dec;
            bus.clock_halt <= shadow[0][7];
            bus.bcd_err    <= sec_bad | min_bad | hr_bad | cal_bad;
         end
      end
   end

`ifdef RTC_DATE_EN
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         bus.day_bin   <= '0;
         bus.date_bin  <= '0;
         bus.month_bin <= '0;
         bus.year_bin  <= '0;
      end else if (state == PUBLISH) begin
         bus.day_bin   <= day_dec;
         bus.date_bin  <= date_dec;
         bus.month_bin <= month_dec;
         bus.year_bin  <= year_dec;
      end
   end
`else
   assign bus.day_bin   = '0;
   assign bus.date_bin  = '0;
   assign bus.month_bin = '0;
   assign bus.year_bin  = '0;
`endif

endmodule

// File: tb/tb_rtc_time_collector.sv
// Randomized bench for rtc_time_collector: a per-address byte ROM stands in for
// the reader stage and an arithmetic model predicts addresses, strobes and fields.
module tb_rtc_time_collector;
   localparam int FC = 16;
   localparam int HF = 2;
`ifdef RTC_DATE_EN
   localparam int LAST = 6;
`else
   localparam int LAST = 2;
`endif
   localparam int R = HF * FC + 1;
   localparam int P = (LAST + 1) * R + 1;

   typedef struct {
      int sec, min, hour, ch, err, day, date, month, year;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rtc_time_collector_if bus ();
   rtc_time_collector #(.FRAME_CYCLES(FC), .HOLD_FRAMES(HF)) dut (
      .clk_50mhz(clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   logic [7:0]  rom [0:7];
   logic [63:0] cur;
   logic [63:0] plan [$];
   int total = 0;
   int bad   = 0;
   int k     = 0;

   function automatic int reg_of(input logic [7:0] a);
      int r = 0;
      for (int i = 0; i < 8; i++) if (a[i]) r += 1 << (7 - i);
      return r;
   endfunction

   function automatic logic [7:0] addr_of(input int r);
      logic [7:0] a = 8'h00;
      for (int i = 0; i < 8; i++) a[7 - i] = ((r >> i) & 1) != 0;
      return a;
   endfunction

   always_comb bus.rd_data = rom[3'(reg_of(bus.rd_addr))];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, k);
      end
   endtask

   task automatic load(input logic [63:0] v);
      for (int i = 0; i < 8; i++) rom[i] = v[i*8 +: 8];
   endtask

   function automatic exp_t model(input logic [63:0] v);
      exp_t e;
      int s, m, h, u, t, x, hr, pm;
      bit b;
      s = int'(v[7:0]); m = int'(v[15:8]); h = int'(v[23:16]);
      e.err = 0;
      u = s % 16; x = 10 * ((s / 16) % 8) + u; b = (u > 9) || (x > 59);
      e.sec = b ? 59 : x; e.err |= int'(b); e.ch = s / 128;
      u = m % 16; x = 10 * ((m / 16) % 8) + u; b = (u > 9) || (x > 59);
      e.min = b ? 59 : x; e.err |= int'(b);
      u = h % 16;
      if ((h / 64) % 2 == 0) begin
         x = 10 * ((h / 16) % 4) + u; b = (u > 9) || (x > 23); hr = x;
      end else begin
         x = 10 * ((h / 16) % 2) + u; pm = (h / 32) % 2;
         b = (u > 9) || (x < 1) || (x > 12);
         if (x == 12) hr = pm ? 12 : 0;
         else         hr = pm ? x + 12 : x;
      end
      e.hour = b ? 23 : hr; e.err |= int'(b);
`ifdef RTC_DATE_EN
      x = int'(v[31:24]) % 8; b = (x == 0);
      e.day = b ? 7 : x; e.err |= int'(b);
      t = int'(v[39:32]); u = t % 16; x = 10 * ((t / 16) % 4) + u;
      b = (u > 9) || (x == 0) || (x > 31); e.date = b ? 31 : x; e.err |= int'(b);
      t = int'(v[47:40]); u = t % 16; x = 10 * ((t / 16) % 2) + u;
      b = (u > 9) || (x == 0) || (x > 12); e.month = b ? 12 : x; e.err |= int'(b);
      t = int'(v[55:48]); u = t % 16; x = 10 * (t / 16) + u;
      b = (u > 9) || (x > 99); e.year = b ? 99 : x; e.err |= int'(b);
`else
      t = 0;
      e.day = 0; e.date = 0; e.month = 0; e.year = 0;
`endif
      return e;
   endfunction

   function automatic logic [7:0] rand_bcd(input int hi);
      int n = $urandom_range(hi);
      return 8'(((n / 10) << 4) | (n % 10));
   endfunction

   function automatic logic [63:0] rand_set();
      logic [63:0] v = {$urandom, $urandom};
      if ($urandom_range(1) == 0) begin
         v[7:0]   = rand_bcd(59) | (8'($urandom_range(1)) << 7);
         v[15:8]  = rand_bcd(59);
         if ($urandom_range(1) == 0) v[23:16] = rand_bcd(23);
         else v[23:16] = 8'h40 | (8'($urandom_range(1)) << 5) | rand_bcd(11) + 8'h01;
         v[31:24] = 8'($urandom_range(7, 1));
         v[39:32] = rand_bcd(30) + 8'h01;
         v[47:40] = rand_bcd(11) + 8'h01;
         v[55:48] = rand_bcd(99);
      end
      return v;
   endfunction

   task automatic check_fields(input string tag, input exp_t e);
      check({tag, ".sec"},   32'(bus.sec_bin),    e.sec);
      check({tag, ".min"},   32'(bus.min_bin),    e.min);
      check({tag, ".hour"},  32'(bus.hour_bin),   e.hour);
      check({tag, ".ch"},    32'(bus.clock_halt), e.ch);
      check({tag, ".err"},   32'(bus.bcd_err),    e.err);
      check({tag, ".day"},   32'(bus.day_bin),    e.day);
      check({tag, ".date"},  32'(bus.date_bin),   e.date);
      check({tag, ".month"}, 32'(bus.month_bin),  e.month);
      check({tag, ".year"},  32'(bus.year_bin),   e.year);
   endtask

   task automatic run_cycles(input int n);
      int p, idx;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         k++;
         p = k % P;
         idx = (p / R > LAST) ? LAST : p / R;
         check("rd_addr", 32'(bus.rd_addr), 32'(addr_of(idx)));
         check("time_valid", 32'(bus.time_valid), 32'(p == 0));
         if (p == 0) begin
            check_fields("set", model(cur));
            cur = (plan.size() > 0) ? plan.pop_front() : rand_set();
            load(cur);
         end
      end
   endtask

   initial begin
      exp_t zero;
      zero = '{default: 0};
      plan.push_back(64'h00_99_12_31_03_23_59_45);
      plan.push_back(64'h00_99_12_31_03_52_00_00);
      plan.push_back(64'h00_99_12_31_03_72_00_00);
      plan.push_back(64'h00_99_12_31_03_67_00_00);
      plan.push_back(64'h00_99_12_31_03_10_30_BA);
      for (int i = 0; i < 14; i++) plan.push_back(rand_set());

      rst_n = 1'b0;
      cur = plan.pop_front();
      load(cur);
      repeat (3) @(negedge clk);
      check("rst.rd_addr", 32'(bus.rd_addr), 32'h00);
      check("rst.time_valid", 32'(bus.time_valid), 0);
      check_fields("rst", zero);
      rst_n = 1'b1;
      k = 0;
      run_cycles(P * 20);

      // Reset while index 1 is being held: the set in flight is abandoned.
      while ((k % P) != R + 7) run_cycles(1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.rd_addr", 32'(bus.rd_addr), 32'h00);
      check("midrst.time_valid", 32'(bus.time_valid), 0);
      check_fields("midrst", zero);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      run_cycles(P * 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
